div_freq_prog: RTL and testbench

//   Run-time programmable clock divider. Generates clk_out at f_clk/N with a

---
 rtl/div_freq_prog.sv | 135 +++++++++++++
 tb/tb_div_freq_prog.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_freq_prog.sv
// Run-time programmable clock divider with period-boundary config reload.
// clk_out_o is H cycles high then N-H cycles low; tick_o marks each period start.
// Optional build macro: ODD_50_EN -- exact 50% duty for odd N using a negedge retime stage.
module div_freq_prog #(
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned DIV_DEFAULT  = 100,
  parameter int unsigned HIGH_DEFAULT = 50
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_n_i,
  input  logic [CNT_W-1:0] div_high_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] NDefault = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] HDefault = CNT_W'(HIGH_DEFAULT);
  localparam logic [CNT_W-1:0] One      = CNT_W'(1);
  localparam logic [CNT_W-1:0] Two      = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] pend_n_q, pend_n_d;
  logic [CNT_W-1:0] pend_h_q, pend_h_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             pos_q, pos_d;

  logic cfg_xfer;
  logic cfg_legal;
  logic at_end;

  assign cfg_xfer  = cfg_valid_i && !pend_q;
  assign cfg_legal = (div_n_i >= Two) && (div_high_i >= One) && (div_high_i < div_n_i);
  // cnt_q never exceeds n_q - 1, so this compare is the only wrap condition needed.
  assign at_end    = (cnt_q == (n_q - One));

  // Next-state: config capture, period counting and boundary reload.
  always_comb begin
    cnt_d    = cnt_q;
    n_d      = n_q;
    h_d      = h_q;
    pend_d   = pend_q;
    pend_n_d = pend_n_q;
    pend_h_d = pend_h_q;
    err_d    = 1'b0;
    pos_d    = pos_q;

    // Transfer and apply are mutually exclusive: transfer needs pend_q=0, apply needs pend_q=1.
    if (cfg_xfer) begin
      if (cfg_legal) begin
        pend_d   = 1'b1;
        pend_n_d = div_n_i;
        pend_h_d = div_high_i;
      end else begin
        err_d = 1'b1;
      end
    end

    if (en_i) begin
      if (at_end) begin
        cnt_d = '0;
        if (pend_q) begin
          n_d    = pend_n_q;
          h_d    = pend_h_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + One;
      end
`ifdef ODD_50_EN
      // (N>>1)+1 equals (N+1)/2 for odd N without needing a carry bit.
      if (n_d[0]) begin
        pos_d = (cnt_d < ((n_d >> 1) + One));
      end else begin
        pos_d = (cnt_d < h_d);
      end
`else
      pos_d = (cnt_d < h_d);
`endif
    end
  end

  // State registers, all reset asynchronously to the default ratio.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      n_q      <= NDefault;
      h_q      <= HDefault;
      pend_q   <= 1'b0;
      pend_n_q <= '0;
      pend_h_q <= '0;
      err_q    <= 1'b0;
      pos_q    <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      h_q      <= h_d;
      pend_q   <= pend_d;
      pend_n_q <= pend_n_d;
      pend_h_q <= pend_h_d;
      err_q    <= err_d;
      pos_q    <= pos_d;
    end
  end

`ifdef ODD_50_EN
  logic neg_q;

  // Half-cycle retime of the high phase; ANDed in for odd N to trim half a cycle.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_q <= 1'b1;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clk_out_o = n_q[0] ? (pos_q & neg_q) : pos_q;
`else
  assign clk_out_o = pos_q;
`endif

  assign cfg_ready_o = !pend_q;
  assign cfg_err_o   = err_q;
  // Reset gate keeps tick low while rst_ni is asserted even though cnt_q is 0.
  assign tick_o      = rst_ni & en_i & (cnt_q == '0);

endmodule

// File: tb/tb_div_freq_prog.sv
// Scoreboard bench for div_freq_prog (default build, ODD_50_EN undefined).
module tb_div_freq_prog;

  localparam int unsigned CntW = 26;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [CntW-1:0] div_n;
  logic [CntW-1:0] div_high;
  logic            cfg_valid;
  logic            cfg_ready;
  logic            cfg_err;
  logic            clk_out;
  logic            tick;

  div_freq_prog #(
    .CNT_W       (CntW),
    .DIV_DEFAULT (100),
    .HIGH_DEFAULT(50)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .div_n_i    (div_n),
    .div_high_i (div_high),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_err_o  (cfg_err),
    .clk_out_o  (clk_out),
    .tick_o     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic clk_out;
    logic tick;
    logic ready;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: position within the current period plus active/pending ratio.
  int unsigned m_pos, m_n, m_h, m_pn, m_ph;
  bit          m_pend, m_err;

  // Period-length bookkeeping: lengths of completed periods, measured from ticks.
  int unsigned m_len;

  function automatic void model_reset();
    m_pos  = 0;
    m_n    = 100;
    m_h    = 50;
    m_pend = 0;
    m_pn   = 0;
    m_ph   = 0;
    m_err  = 0;
  endfunction

  // Apply inputs for one cycle: push expected outputs, then advance to the next edge.
  task automatic cycle(input bit r, input bit e, input bit v,
                       input int unsigned n, input int unsigned h);
    exp_t x;
    bit   legal;
    rst_n     = r;
    en        = e;
    cfg_valid = v;
    div_n     = n[CntW-1:0];
    div_high  = h[CntW-1:0];
    if (!r) model_reset();
    x.clk_out = (m_pos < m_h);
    x.tick    = r && e && (m_pos == 0);
    x.ready   = !m_pend;
    x.err     = m_err;
    exp_q.push_back(x);
    if (r) begin
      legal = (n >= 2) && (h >= 1) && (h < n);
      m_err = v && !m_pend && !legal;
      if (e) begin
        if (m_pos == m_n - 1) begin
          m_pos = 0;
          if (m_pend) begin
            m_n    = m_pn;
            m_h    = m_ph;
            m_pend = 0;
          end
        end else begin
          m_pos++;
        end
      end
      // Capture uses the pre-edge pending flag, so it happens after the apply check.
      if (v && !x.ready == 1'b0 && legal) begin
        m_pend = 1;
        m_pn   = n;
        m_ph   = h;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int unsigned cycles, input bit e);
    for (int i = 0; i < int'(cycles); i++) cycle(1'b1, e, 1'b0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{clk_out: clk_out, tick: tick, ready: cfg_ready, err: cfg_err};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d got clk_out=%b tick=%b ready=%b err=%b exp %b %b %b %b",
                 cyc, a.clk_out, a.tick, a.ready, a.err, e.clk_out, e.tick, e.ready, e.err);
      end
    end
  end

  // Independent period-length checks around the stretch scenario.
  int unsigned tick_gap;
  int unsigned last_tick;
  bit          seen_tick;

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; div_n = '0; div_high = '0;
    seen_tick = 0; tick_gap = 0; last_tick = 0; m_len = 0;
    model_reset();
    @(posedge clk);
    #1;
    // Reset, then defaults: 50 high / 50 low with the first tick in cycle 0.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 0, 0);
    run(230, 1'b1);
    // Mid-period reconfigure to 10/3.
    cycle(1'b1, 1'b1, 1'b1, 10, 3);
    run(120, 1'b1);
    // Illegal requests.
    cycle(1'b1, 1'b1, 1'b1, 1, 0);
    run(3, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 8, 8);
    run(25, 1'b1);
    // Freeze 17 cycles while high (cnt==1 with H=3).
    while (m_pos != 1) cycle(1'b1, 1'b1, 1'b0, 0, 0);
    last_tick = cyc - 1;
    run(17, 1'b0);
    run(9, 1'b1);
    // The frozen period must contain exactly 10+17 cycles, seen directly on tick_o.
    tick_gap = 0;
    for (int i = 0; i < 40 && tick_gap == 0; i++) begin
      if (tick) tick_gap = cyc - last_tick;
      cycle(1'b1, 1'b1, 1'b0, 0, 0);
    end
    checks++;
    if (tick_gap != 27) begin
      failures++;
      $display("FAIL stretch_period got=%0d exp=27", tick_gap);
    end
    // Async reset with a config pending.
    cycle(1'b1, 1'b1, 1'b1, 20, 5);
    run(2, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0, 0);
    run(220, 1'b1);
    // Odd N with H=2 (default build: 2 high / 3 low).
    cycle(1'b1, 1'b1, 1'b1, 5, 2);
    run(130, 1'b1);
    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      bit          r, e, v;
      int unsigned n, h;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 7) == 0);
      n = $urandom_range(0, 14);
      h = $urandom_range(0, 14);
      cycle(r, e, v, n, h);
    end
    run(2, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
